// File: rtl/phy_regread_stage.sv
// phy_regread_stage: register-read stage with skid FIFO, operand forwarding and wb snooping
module phy_regread_stage #(
  parameter int VAL_W     = 32,
  parameter int PREG_W    = 7,
  parameter int PAYLOAD_W = 64,
  parameter int BUF_DEPTH = 4,
  parameter int NUM_WB    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PREG_W-1:0]         in_src1,
  input  logic [PREG_W-1:0]         in_src2,
  input  logic [PREG_W-1:0]         in_dst,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  input  logic [NUM_WB-1:0]         wb_en,
  input  logic [NUM_WB*PREG_W-1:0]  wb_reg,
  input  logic [NUM_WB*VAL_W-1:0]   wb_val,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PREG_W-1:0]         out_src1,
  output logic [PREG_W-1:0]         out_src2,
  output logic [PREG_W-1:0]         out_dst,
  output logic [VAL_W-1:0]          out_val1,
  output logic [VAL_W-1:0]          out_val2,
  output logic [PAYLOAD_W-1:0]      out_payload
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int EW = 3 * PREG_W + PAYLOAD_W;
  localparam logic [CW-1:0] DEPTH = CW'(BUF_DEPTH);

  logic [VAL_W-1:0]     rf [2**PREG_W];
  logic [EW-1:0]        mem [BUF_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 push_in, load, pop, pass, fifo_push, ld_valid;
  logic [EW-1:0]        ld_ent;
  logic [PREG_W-1:0]    ld_src1, ld_src2, ld_dst;
  logic [PAYLOAD_W-1:0] ld_payload;
  logic [VAL_W-1:0]     rd_val1, rd_val2, snp_val1, snp_val2;

  // Overlay same-cycle wb writes on a base value; later ports override earlier ones, r0 is always 0
  function automatic logic [VAL_W-1:0] fwd(
    input logic [PREG_W-1:0]        idx,
    input logic [VAL_W-1:0]         base,
    input logic [NUM_WB-1:0]        en,
    input logic [NUM_WB*PREG_W-1:0] regs,
    input logic [NUM_WB*VAL_W-1:0]  vals
  );
    logic [VAL_W-1:0] v;
    v = base;
    for (int p = 0; p < NUM_WB; p++)
      if (en[p] && regs[p*PREG_W +: PREG_W] == idx) v = vals[p*VAL_W +: VAL_W];
    return (idx == '0) ? '0 : v;
  endfunction

  assign in_ready  = count < DEPTH;
  assign push_in   = in_valid && in_ready && !flush;
  assign load      = !out_valid || out_ready;
  assign pop       = load && count != '0 && !flush;
  assign pass      = load && count == '0 && push_in;
  assign fifo_push = push_in && !pass;
  assign ld_valid  = load && (count != '0 || push_in) && !flush;
  assign ld_ent    = (count != '0) ? mem[rd_ptr] : {in_src1, in_src2, in_dst, in_payload};
  assign {ld_src1, ld_src2, ld_dst, ld_payload} = ld_ent;

  // Operand read ports with forwarding, plus snoop of the held operands
  always_comb begin
    rd_val1  = fwd(ld_src1, rf[ld_src1], wb_en, wb_reg, wb_val);
    rd_val2  = fwd(ld_src2, rf[ld_src2], wb_en, wb_reg, wb_val);
    snp_val1 = fwd(out_src1, out_val1, wb_en, wb_reg, wb_val);
    snp_val2 = fwd(out_src2, out_val2, wb_en, wb_reg, wb_val);
  end

  // Register file: cleared by reset, later write ports win, r0 never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**PREG_W; i++) rf[i] <= '0;
    end else begin
      for (int p = 0; p < NUM_WB; p++)
        if (wb_en[p] && wb_reg[p*PREG_W +: PREG_W] != '0)
          rf[wb_reg[p*PREG_W +: PREG_W]] <= wb_val[p*VAL_W +: VAL_W];
    end
  end

  // Skid FIFO storage holds indices and payload; operands are read on leaving
  always_ff @(posedge clk) begin
    if (fifo_push) mem[wr_ptr] <= {in_src1, in_src2, in_dst, in_payload};
  end

  // Skid FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(fifo_push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(fifo_push) - CW'(pop);
    end
  end

  // Output register: load from FIFO head or pass-through, otherwise hold and snoop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_src1    <= '0;
      out_src2    <= '0;
      out_dst     <= '0;
      out_val1    <= '0;
      out_val2    <= '0;
      out_payload <= '0;
    end else begin
      out_valid <= flush ? 1'b0 : (load ? ld_valid : out_valid);
      if (ld_valid) begin
        out_src1    <= ld_src1;
        out_src2    <= ld_src2;
        out_dst     <= ld_dst;
        out_val1    <= rd_val1;
        out_val2    <= rd_val2;
        out_payload <= ld_payload;
      end else begin
        out_val1 <= snp_val1;
        out_val2 <= snp_val2;
      end
    end
  end
endmodule

// File: tb/tb_phy_regread_stage.sv
// tb_phy_regread_stage: directed self-checking bench for phy_regread_stage
module tb_phy_regread_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [6:0]  in_src1, in_src2, in_dst;
  logic [63:0] in_payload;
  logic [1:0]  wb_en;
  logic [13:0] wb_reg;
  logic [63:0] wb_val;
  logic        flush;
  logic        out_valid, out_ready;
  logic [6:0]  out_src1, out_src2, out_dst;
  logic [31:0] out_val1, out_val2;
  logic [63:0] out_payload;
  int          checks = 0;
  int          errors = 0;

  phy_regread_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst), .in_payload(in_payload),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_val(wb_val),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src1(out_src1), .out_src2(out_src2), .out_dst(out_dst),
    .out_val1(out_val1), .out_val2(out_val2), .out_payload(out_payload)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [1:0] en, input logic [6:0] r0, input logic [31:0] v0,
                    input logic [6:0] r1, input logic [31:0] v1);
    wb_en  = en;
    wb_reg = {r1, r0};
    wb_val = {v1, v0};
  endtask

  task automatic issue(input logic v, input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] d, input logic [63:0] pl);
    in_valid   = v;
    in_src1    = s1;
    in_src2    = s2;
    in_dst     = d;
    in_payload = pl;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    issue(1'b0, 7'd0, 7'd0, 7'd0, 64'd0);
    wb(2'b00, 7'd0, 32'd0, 7'd0, 32'd0);
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_val1", out_val1, 0);
    chk("rst_payload", out_payload, 0);
    tick();
    tick();
    reset = 1'b0;

    // pass-through
    wb(2'b01, 7'd5, 32'hAA, 7'd0, 32'd0);
    tick();
    wb(2'b00, 7'd0, 32'd0, 7'd0, 32'd0);
    out_ready = 1'b1;
    issue(1'b1, 7'd5, 7'd0, 7'd7, 64'hDEAD_BEEF_0000_0001);
    tick();
    issue(1'b0, 7'd0, 7'd0, 7'd0, 64'd0);
    chk("pt_valid", out_valid, 1);
    chk("pt_val1", out_val1, 32'hAA);
    chk("pt_val2", out_val2, 0);
    chk("pt_dst", out_dst, 7);
    chk("pt_payload", out_payload, 64'hDEAD_BEEF_0000_0001);
    tick();
    chk("pt_drained", out_valid, 0);

    // back-pressure: 1 in output register plus 4 buffered
    wb(2'b11, 7'd10, 32'h10, 7'd11, 32'h11);
    tick();
    wb(2'b11, 7'd12, 32'h12, 7'd13, 32'h13);
    tick();
    wb(2'b01, 7'd14, 32'h14, 7'd0, 32'd0);
    tick();
    wb(2'b00, 7'd0, 32'd0, 7'd0, 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_ready_%0d", i), in_ready, 1);
      issue(1'b1, 7'(10 + i), 7'd0, 7'd1, 64'(i));
      tick();
    end
    issue(1'b0, 7'd0, 7'd0, 7'd0, 64'd0);
    chk("bp_full", in_ready, 0);
    chk("bp_hold_valid", out_valid, 1);
    tick();
    chk("bp_hold_val1", out_val1, 32'h10);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_%0d", i), out_valid, 1);
      chk($sformatf("bp_val1_%0d", i), out_val1, 64'(32'h10 + i));
      chk($sformatf("bp_payload_%0d", i), out_payload, 64'(i));
      tick();
      if (i == 0) chk("bp_ready_after_pop", in_ready, 1);
    end
    chk("bp_empty", out_valid, 0);

    // forwarding into load, then snoop while held
    issue(1'b1, 7'd9, 7'd9, 7'd2, 64'h55AA);
    wb(2'b01, 7'd9, 32'h1234, 7'd0, 32'd0);
    tick();
    chk("fw_val2", out_val2, 32'h1234);
    chk("fw_val1", out_val1, 32'h1234);
    issue(1'b0, 7'd0, 7'd0, 7'd0, 64'd0);
    out_ready = 1'b0;
    wb(2'b10, 7'd0, 32'd0, 7'd9, 32'h55);
    tick();
    wb(2'b00, 7'd0, 32'd0, 7'd0, 32'd0);
    chk("snp_val1", out_val1, 32'h55);
    chk("snp_val2", out_val2, 32'h55);
    chk("snp_valid", out_valid, 1);
    chk("snp_payload", out_payload, 64'h55AA);
    out_ready = 1'b1;
    tick();
    chk("snp_drained", out_valid, 0);

    // write-port conflict and hardwired r0
    wb(2'b11, 7'd3, 32'h1, 7'd3, 32'h2);
    tick();
    wb(2'b01, 7'd0, 32'hFF, 7'd0, 32'd0);
    tick();
    issue(1'b1, 7'd3, 7'd4, 7'd0, 64'd0);
    wb(2'b11, 7'd4, 32'h8, 7'd4, 32'h9);
    tick();
    chk("conf_reg3", out_val1, 32'h2);
    chk("conf_fwd4", out_val2, 32'h9);
    issue(1'b1, 7'd0, 7'd4, 7'd0, 64'd0);
    wb(2'b10, 7'd0, 32'd0, 7'd0, 32'hFF);
    tick();
    issue(1'b0, 7'd0, 7'd0, 7'd0, 64'd0);
    wb(2'b00, 7'd0, 32'd0, 7'd0, 32'd0);
    chk("r0_read", out_val1, 0);
    chk("conf_arr4", out_val2, 32'h9);
    tick();

    // flush with buffered beats and a live input beat
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 7'd0, 7'd0, 7'd0, 64'(32'hF0 + i));
      tick();
    end
    chk("fl_pre_valid", out_valid, 1);
    issue(1'b1, 7'd0, 7'd0, 7'd0, 64'hBAD);
    flush = 1'b1;
    wb(2'b01, 7'd20, 32'h77, 7'd0, 32'd0);
    tick();
    flush = 1'b0;
    issue(1'b0, 7'd0, 7'd0, 7'd0, 64'd0);
    wb(2'b00, 7'd0, 32'd0, 7'd0, 32'd0);
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    chk("fl_lost", out_valid, 0);
    issue(1'b1, 7'd20, 7'd0, 7'd0, 64'h99);
    tick();
    issue(1'b0, 7'd0, 7'd0, 7'd0, 64'd0);
    chk("fl_new_valid", out_valid, 1);
    chk("fl_wb_kept", out_val1, 32'h77);
    chk("fl_new_payload", out_payload, 64'h99);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    issue(1'b1, 7'd5, 7'd0, 7'd0, 64'h1);
    tick();
    issue(1'b0, 7'd0, 7'd0, 7'd0, 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_ready", in_ready, 1);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("ar_no_beat", out_valid, 0);
    issue(1'b1, 7'd5, 7'd3, 7'd0, 64'd0);
    tick();
    chk("ar_reg5", out_val1, 0);
    chk("ar_reg3", out_val2, 0);
    issue(1'b1, 7'd9, 7'd20, 7'd0, 64'd0);
    tick();
    issue(1'b0, 7'd0, 7'd0, 7'd0, 64'd0);
    chk("ar_reg9", out_val1, 0);
    chk("ar_reg20", out_val2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/phy_regread_stage.md
PHY_REGREAD_STAGE -- requirements
Module: phy_regread_stage

Interface
REQ-001 SHALL have parameter VAL_W, 32, operand value width in bits.
REQ-002 SHALL have parameter PREG_W, 7, physical register index width; the register file holds 2**PREG_W entries.
REQ-003 SHALL have parameter PAYLOAD_W, 64, width of the opaque side-band payload (control, pc, immediate) carried with each instruction.
REQ-004 SHALL have parameter BUF_DEPTH, 4, skid FIFO depth; legal values are powers of two, 2 or greater.
REQ-005 SHALL have parameter NUM_WB, 2, number of commit write ports.
REQ-006 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port in_valid  in  1  incoming instruction valid.
REQ-009 SHALL have port in_ready  out  1  stage can accept an instruction.
REQ-010 SHALL have port in_src1, in_src2, in_dst  in  PREG_W each  physical source and destination indices.
REQ-011 SHALL have port in_payload  in  PAYLOAD_W  side-band data.
REQ-012 SHALL have port wb_en  in  NUM_WB  per-port commit write enable.
REQ-013 SHALL have port wb_reg  in  NUM_WB*PREG_W  per-port write index, packed with port 0 in the LSBs.
REQ-014 SHALL have port wb_val  in  NUM_WB*VAL_W  per-port write data, packed with port 0 in the LSBs.
REQ-015 SHALL have port flush  in  1  synchronous discard of all in-flight instructions.
REQ-016 SHALL have port out_valid  out  1  output register holds a valid instruction.
REQ-017 SHALL have port out_ready  in  1  downstream accepts the instruction.
REQ-018 SHALL have port out_src1, out_src2, out_dst  out  PREG_W each  registered indices.
REQ-019 SHALL have port out_val1, out_val2  out  VAL_W each  registered operand values.
REQ-020 SHALL have port out_payload  out  PAYLOAD_W  registered side-band data.

Function
REQ-021 SHALL accept an input beat when in_valid and in_ready are both high at a clock edge; in_ready SHALL equal (count < BUF_DEPTH) and SHALL be independent of out_ready.
REQ-022 SHALL hold the output register when out_valid=1 and out_ready=0; all out_* fields SHALL be stable except operand snooping per REQ-027.
REQ-023 SHALL load the output register when it is empty or is being drained (out_valid and out_ready): from the FIFO head if count>0, otherwise directly from an accepted input beat (pass-through).
REQ-024 SHALL give pass-through latency of 1 cycle: a beat accepted at edge N appears with out_valid=1 after edge N; sustained throughput SHALL be 1 instruction per cycle.
REQ-025 SHALL implement the FIFO with read/write pointers wrapping modulo BUF_DEPTH and a count of width clog2(BUF_DEPTH+1); a simultaneous push and pop when full or empty SHALL keep the count correct, and order SHALL be preserved.
REQ-026 SHALL read operand values when loading the output register; a wb write in the same cycle to the read index SHALL be forwarded, so the new value is captured.
REQ-027 SHALL snoop wb writes while holding the output register: a write matching out_src1 or out_src2 SHALL update out_val1 or out_val2 at the same edge.
REQ-028 SHALL write the register file at the edge for each port with wb_en=1; if several ports target the same index, the highest-numbered port SHALL win, for the array, forwarding and snooping alike.
REQ-029 SHALL hardwire physical register 0: writes to it are ignored, and reads, forwarding and snooping return 0.
REQ-030 SHALL, on flush=1 at an edge, set count to 0, reset the pointers, clear out_valid and discard any input beat in that cycle; register file writes in that cycle SHALL still occur.

Reset
REQ-031 SHALL, while reset is high, force every register file entry to 0, count and pointers to 0, out_valid=0, all out_* data to 0, and in_ready=1.
REQ-032 SHALL, when reset asserts mid-operation, discard all buffered instructions, with no output beat on the first edge after reset is released.

Verification
REQ-033 Pass-through: empty stage, out_ready=1, issue src1=5 holding 0xAA → next cycle out_valid=1, out_val1=0xAA, same payload.
REQ-034 Back-pressure: out_ready=0, issue 5 beats with BUF_DEPTH=4 → one beat in the output register plus 4 in the FIFO; in_ready=0 after the 5th; raise out_ready → beats drain in order, 1 per cycle.
REQ-035 Forwarding: wb port0 writes reg 9=0x1234 in the same cycle an instruction with src2=9 loads → out_val2=0x1234; held output with src1=9 and wb reg 9=0x55 → out_val1 becomes 0x55.
REQ-036 Write conflict and r0: port0 and port1 both write reg 3 (0x1, 0x2) → reg 3 reads 0x2; a write of 0xFF to reg 0 → reads of reg 0 return 0.
REQ-037 Flush: FIFO count=3, out_valid=1, in_valid=1, flush=1 → next cycle count=0, out_valid=0, in_ready=1, and the input beat is lost.
REQ-038 Async reset mid-stream: assert reset between edges → out_valid=0 and in_ready=1 immediately, and all register entries read 0.
